// File: rtl/skew_feeder.sv
// Skewed west-edge feeder for the systolic array: row r reads its buffer r cycles late.
// Optional build macro INPUT_ZERO_PAD_EN zero-fills dataOut outside the skew window.
module skew_feeder #(
  parameter int matrixSize = 4,
  parameter int dataSize   = 16
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             start,
  output logic                                             busy,
  output logic                                             done,
  output logic [matrixSize*((matrixSize > 1) ? $clog2(matrixSize) : 1)-1:0] readLocation,
  input  logic [matrixSize*dataSize-1:0]                   readElement,
  output logic [matrixSize*dataSize-1:0]                   dataOut,
  output logic [matrixSize-1:0]                            validOut
);

  localparam int W  = (matrixSize > 1) ? $clog2(matrixSize) : 1;
  localparam int TW = ($clog2(2*matrixSize) > 0) ? $clog2(2*matrixSize) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(2*matrixSize-2);
  localparam logic [TW-1:0] K_MAX  = TW'(matrixSize-1);

  typedef enum logic [0:0] {IDLE = 1'b0, FEED = 1'b1} state_e;

  state_e                         state_q, state_d;
  logic [TW-1:0]                  t_q, t_d;
  logic                           done_q, done_d;
  logic [matrixSize-1:0]          valid_q, valid_d;
  logic [matrixSize*dataSize-1:0] data_q, data_d;
  logic [matrixSize*W-1:0]        read_loc_s;
  logic [matrixSize-1:0]          in_range_s;
  logic [TW-1:0]                  diff_s [matrixSize];

  // Lane window decode; t >= r is tested first so t-r never wraps.
  always_comb begin
    read_loc_s = '0;
    for (int r = 0; r < matrixSize; r++) begin
      diff_s[r]     = t_q - TW'(r);
      in_range_s[r] = (state_q == FEED) && (t_q >= TW'(r)) && (diff_s[r] <= K_MAX);
      if (in_range_s[r]) begin
        read_loc_s[r*W +: W] = W'(diff_s[r]);
      end else begin
        read_loc_s[r*W +: W] = '0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    done_d  = 1'b0;
    valid_d = '0;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FEED;
          t_d     = '0;
        end else begin
          state_d = IDLE;
        end
`ifdef INPUT_ZERO_PAD_EN
        data_d = '0;
`endif
      end
      FEED: begin
        for (int r = 0; r < matrixSize; r++) begin
          valid_d[r] = in_range_s[r];
          if (in_range_s[r]) begin
            data_d[r*dataSize +: dataSize] = readElement[r*dataSize +: dataSize];
          end else begin
`ifdef INPUT_ZERO_PAD_EN
            data_d[r*dataSize +: dataSize] = '0;
`else
            data_d[r*dataSize +: dataSize] = data_q[r*dataSize +: dataSize];
`endif
          end
        end
        if (t_q == T_LAST) begin
          state_d = IDLE;
          t_d     = '0;
          done_d  = 1'b1;
        end else begin
          state_d = FEED;
          t_d     = t_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        t_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      done_q  <= 1'b0;
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign busy         = (state_q == FEED);
  assign done         = done_q;
  assign validOut     = valid_q;
  assign dataOut      = data_q;
  assign readLocation = read_loc_s;

endmodule

// File: tb/tb_skew_feeder.sv
// Scoreboard bench for skew_feeder (matrixSize=4, dataSize=16); honours INPUT_ZERO_PAD_EN.
module tb_skew_feeder;
  localparam int N = 4;
  localparam int D = 16;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic [N-1:0]  valid;
    logic [2*N-1:0] rloc;
    logic [N-1:0]  dchk;
    logic [N*D-1:0] data;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst, start, busy, done;
  logic [2*N-1:0] readLocation;
  logic [N*D-1:0] readElement, dataOut;
  logic [N-1:0]   validOut;
  logic [D-1:0]   buf_mem [N][N];

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  skew_feeder #(.matrixSize(N), .dataSize(D)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .readLocation(readLocation), .readElement(readElement),
    .dataOut(dataOut), .validOut(validOut)
  );

  always #5 clk = ~clk;

  // Row buffers: combinational read from the per-lane index.
  always_comb begin
    readElement = '0;
    for (int r = 0; r < N; r++) readElement[r*D +: D] = buf_mem[r][readLocation[r*2 +: 2]];
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected sample j cycles after the start edge E0 (j = 0..7).
  function automatic exp_t make_rec(int j);
    exp_t e;
    int   k;
    e      = '0;
    e.busy = (j <= 6);
    e.done = (j == 7);
    for (int r = 0; r < N; r++) begin
      if (j <= 6 && j >= r && j - r <= N - 1) e.rloc[r*2 +: 2] = 2'(j - r);
      k = j - 1 - r;
      if (j >= 1 && k >= 0 && k <= N - 1) begin
        e.valid[r] = 1'b1;
        e.dchk[r]  = 1'b1;
        e.data[r*D +: D] = buf_mem[r][k];
      end else if (j >= 1 && k > N - 1) begin
        e.dchk[r] = 1'b1;
`ifdef INPUT_ZERO_PAD_EN
        e.data[r*D +: D] = 16'h0000;
`else
        e.data[r*D +: D] = buf_mem[r][N-1];
`endif
      end else begin
`ifdef INPUT_ZERO_PAD_EN
        e.dchk[r] = 1'b1;
`endif
      end
    end
    return e;
  endfunction

  task automatic check_cycle();
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_val("busy", 64'(busy), 64'(e.busy));
      check_val("done", 64'(done), 64'(e.done));
      check_val("validOut", 64'(validOut), 64'(e.valid));
      check_val("readLocation", 64'(readLocation), 64'(e.rloc));
      for (int r = 0; r < N; r++)
        if (e.dchk[r]) check_val($sformatf("dataOut[%0d]", r), 64'(dataOut[r*D +: D]), 64'(e.data[r*D +: D]));
    end else begin
      check_val("idle_busy", 64'(busy), 64'd0);
      check_val("idle_done", 64'(done), 64'd0);
      check_val("idle_valid", 64'(validOut), 64'd0);
      check_val("idle_rloc", 64'(readLocation), 64'd0);
`ifdef INPUT_ZERO_PAD_EN
      check_val("idle_data", 64'(dataOut), 64'd0);
`endif
    end
  endtask

  task automatic cyc(input logic st, input logic rs);
    exp_t z;
    start = st;
    rst   = rs;
    if (rs) begin
      sb.delete();
      z      = '0;
      z.dchk = '1;
      sb.push_back(z);
    end else if (st && sb.size() == 0) begin
      for (int j = 0; j <= 7; j++) sb.push_back(make_rec(j));
    end
    @(posedge clk);
    @(negedge clk);
    check_cycle();
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    for (int r = 0; r < N; r++)
      for (int k = 0; k < N; k++) buf_mem[r][k] = 16'(r*16 + k);
    @(negedge clk);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    repeat (5) cyc(1'b0, 1'b0);
    // single pass
    cyc(1'b1, 1'b0);
    repeat (8) cyc(1'b0, 1'b0);
    // start held high: back-to-back passes
    repeat (18) cyc(1'b1, 1'b0);
    repeat (10) cyc(1'b0, 1'b0);
    // start pulse at t=3 is ignored
    cyc(1'b1, 1'b0);
    repeat (2) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    repeat (6) cyc(1'b0, 1'b0);
    // reset during t=2 aborts the pass
    cyc(1'b1, 1'b0);
    repeat (2) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    repeat (10) cyc(1'b0, 1'b0);
    // fresh pass with random buffer contents
    for (int r = 0; r < N; r++)
      for (int k = 0; k < N; k++) buf_mem[r][k] = 16'($urandom);
    cyc(1'b1, 1'b0);
    repeat (9) cyc(1'b0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
